cuckoo_hash_engine: RTL and testbench

Parametrised two-table cuckoo hash engine. It performs insert with iterative eviction bounded by a kick limit, plus lookup, delete and clear, behind a valid/ready request port and a one-cycle response pulse. It is the multi-step successor to the single-step table-1 insert/evict stage. Each key table is held in registers, so probes complete in one cycle.

---
 rtl/cuckoo_hash_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_cuckoo_hash_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cuckoo_hash_engine.sv
// Two-table cuckoo hash engine: lookup, insert with bounded eviction, delete and clear.
// Both tables live in registers, so every probe or kick step finishes in one cycle.

module cuckoo_tbl #(
  parameter int KEY_W = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [KEY_W-1:0]            wr_key,
  input  logic                        del_en,
  input  logic [IDX_W-1:0]            del_idx,
  output logic [DEPTH-1:0][KEY_W-1:0] keys,
  output logic [DEPTH-1:0]            vld
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= '0;
    end else begin
      if (wr_en)  vld[wr_idx]  <= 1'b1;
      if (del_en) vld[del_idx] <= 1'b0;
    end
  end

  // Key storage carries no reset; the valid bit alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) keys[wr_idx] <= wr_key;
  end

endmodule

module cuckoo_hash_engine #(
  parameter  int KEY_W     = 32,
  parameter  int DEPTH     = 16,
  parameter  int MAX_KICKS = 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [KEY_W-1:0] req_key,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             resp_fail,
  output logic [KEY_W-1:0] resp_key,
  output logic [IDX_W:0]   resp_loc,
  output logic [IDX_W+1:0] count
);

  localparam int KC_W = $clog2(MAX_KICKS + 1);
  localparam logic [1:0] OP_LKP = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {IDLE, PROBE, KICK, RESP} state_t;
  state_t state, state_nx;

  logic [1:0]             op_q;
  logic [KEY_W-1:0]       key_q;
  logic [KEY_W-1:0]       cur;
  logic                   side;
  logic [KC_W-1:0]        kicks;

  logic [1:0][DEPTH-1:0][KEY_W-1:0] tkeys;
  logic [1:0][DEPTH-1:0]            tvld;
  logic [1:0]                       wr_en, del_en;
  logic [1:0][IDX_W-1:0]            wr_idx, del_idx;
  logic [1:0][KEY_W-1:0]            wr_key;
  logic                             tbl_clr;

  for (genvar t = 0; t < 2; t++) begin : g_tbl
    cuckoo_tbl #(.KEY_W(KEY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_tbl (
      .clk     (clk),
      .rst     (rst),
      .clr     (tbl_clr),
      .wr_en   (wr_en[t]),
      .wr_idx  (wr_idx[t]),
      .wr_key  (wr_key[t]),
      .del_en  (del_en[t]),
      .del_idx (del_idx[t]),
      .keys    (tkeys[t]),
      .vld     (tvld[t])
    );
  end

  // Probe of the latched request key against both candidate slots.
  logic [IDX_W-1:0] h1q, h2q, kidx;
  logic             v1, v2, m1, m2, hit, kvld, last_kick;
  logic [IDX_W:0]   hit_loc;
  logic [KEY_W-1:0] kocc;

  always_comb begin
    h1q       = key_q[IDX_W-1:0];
    h2q       = key_q[2*IDX_W-1:IDX_W];
    v1        = tvld[0][h1q];
    v2        = tvld[1][h2q];
    m1        = v1 && (tkeys[0][h1q] == key_q);
    m2        = v2 && (tkeys[1][h2q] == key_q);
    hit       = m1 || m2;
    hit_loc   = m1 ? {1'b0, h1q} : (m2 ? {1'b1, h2q} : '0);
    kidx      = side ? cur[2*IDX_W-1:IDX_W] : cur[IDX_W-1:0];
    kvld      = tvld[side][kidx];
    kocc      = tkeys[side][kidx];
    last_kick = (kicks == KC_W'(MAX_KICKS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (req_valid) state_nx = PROBE;
      PROBE: state_nx = (op_q == OP_INS && !hit && v1 && v2) ? KICK : RESP;
      KICK:  if (!kvld || last_kick) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    wr_en      = '0;
    wr_idx     = '0;
    wr_key     = '0;
    del_en     = '0;
    del_idx    = '0;
    tbl_clr    = 1'b0;
    case (state)
      PROBE: begin
        case (op_q)
          OP_INS: if (!hit) begin
            if (!v1) begin
              wr_en[0] = 1'b1; wr_idx[0] = h1q; wr_key[0] = key_q;
            end else if (!v2) begin
              wr_en[1] = 1'b1; wr_idx[1] = h2q; wr_key[1] = key_q;
            end
          end
          OP_DEL: begin
            if (m1) begin
              del_en[0] = 1'b1; del_idx[0] = h1q;
            end else if (m2) begin
              del_en[1] = 1'b1; del_idx[1] = h2q;
            end
          end
          OP_CLR: tbl_clr = 1'b1;
          default: ;
        endcase
      end
      // Every kick writes cur, whether the slot was empty or held a victim.
      KICK: begin
        wr_en[side]  = 1'b1;
        wr_idx[side] = kidx;
        wr_key[side] = cur;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      key_q     <= '0;
      cur       <= '0;
      side      <= 1'b0;
      kicks     <= '0;
      resp_hit  <= 1'b0;
      resp_fail <= 1'b0;
      resp_key  <= '0;
      resp_loc  <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q  <= req_op;
          key_q <= req_key;
        end
        PROBE: begin
          resp_key  <= key_q;
          resp_fail <= 1'b0;
          resp_hit  <= hit;
          resp_loc  <= hit_loc;
          case (op_q)
            OP_DEL: if (hit) count <= count - 1'b1;
            OP_CLR: begin
              resp_hit <= 1'b0;
              resp_loc <= '0;
              count    <= '0;
            end
            OP_INS: if (!hit) begin
              if (!v1) begin
                resp_loc <= {1'b0, h1q};
                count    <= count + 1'b1;
              end else if (!v2) begin
                resp_loc <= {1'b1, h2q};
                count    <= count + 1'b1;
              end else begin
                cur   <= key_q;
                side  <= 1'b0;
                kicks <= '0;
              end
            end
            default: ;
          endcase
        end
        KICK: begin
          if (!kvld) begin
            resp_loc <= {side, kidx};
            count    <= count + 1'b1;
          end else begin
            cur   <= kocc;
            kicks <= kicks + 1'b1;
            side  <= ~side;
            // Out of kicks: the last victim is reported homeless, count is net zero.
            if (last_kick) begin
              resp_fail <= 1'b1;
              resp_key  <= kocc;
              resp_loc  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cuckoo_hash_engine.sv
// Bench for cuckoo_hash_engine (DEPTH=4, MAX_KICKS=4, KEY_W=8): vector table plus
// hand sequences for reset abort and held requests, checked through a response scoreboard.

module tb_cuckoo_hash_engine;

  localparam int KEY_W = 8;
  localparam int DEPTH = 4;
  localparam int MAXK  = 4;
  localparam logic [1:0] LKP = 2'b00, INS = 2'b01, DEL = 2'b10, CLR = 2'b11;

  logic             clk, rst, req_valid, req_ready;
  logic [1:0]       req_op;
  logic [KEY_W-1:0] req_key;
  logic             resp_valid, resp_hit, resp_fail;
  logic [KEY_W-1:0] resp_key;
  logic [2:0]       resp_loc;
  logic [3:0]       count;

  cuckoo_hash_engine #(.KEY_W(KEY_W), .DEPTH(DEPTH), .MAX_KICKS(MAXK)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_key(req_key), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_fail(resp_fail), .resp_key(resp_key), .resp_loc(resp_loc), .count(count)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] key;
    logic       hit;
    logic       fail;
    logic [7:0] rkey;
    logic [2:0] loc;
    logic [3:0] cnt;
    int         lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   t0;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  sb_t  mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic [1:0] op, logic [7:0] key, logic hit, logic fail,
                              logic [7:0] rkey, logic [2:0] loc, logic [3:0] cnt, int lat);
    vec_t v;
    v.op = op; v.key = key; v.hit = hit; v.fail = fail;
    v.rkey = rkey; v.loc = loc; v.cnt = cnt; v.lat = lat;
    return v;
  endfunction

  // Response monitor: every resp_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("hit key=%0h", mon_e.v.key),  {31'd0, resp_hit},  {31'd0, mon_e.v.hit});
        chk($sformatf("fail key=%0h", mon_e.v.key), {31'd0, resp_fail}, {31'd0, mon_e.v.fail});
        chk($sformatf("rkey key=%0h", mon_e.v.key), {24'd0, resp_key},  {24'd0, mon_e.v.rkey});
        chk($sformatf("loc key=%0h", mon_e.v.key),  {29'd0, resp_loc},  {29'd0, mon_e.v.loc});
        chk($sformatf("count key=%0h", mon_e.v.key), {28'd0, count},    {28'd0, mon_e.v.cnt});
        chk($sformatf("latency key=%0h", mon_e.v.key), cyc - mon_e.t0, mon_e.v.lat);
      end
    end
  end

  // Called at a negedge; returns at a negedge with req_valid low.
  task automatic do_req(vec_t v);
    int w;
    sb_t e;
    req_op = v.op; req_key = v.key; req_valid = 1'b1; w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      e.v = v; e.t0 = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // op key hit fail rkey loc cnt latency
    vecs.push_back(mk(INS, 8'h05, 1, 0, 8'h05, 3'b001, 1, 2));
    vecs.push_back(mk(INS, 8'h05, 1, 0, 8'h05, 3'b001, 1, 2));
    vecs.push_back(mk(INS, 8'h11, 0, 0, 8'h11, 3'b100, 2, 2));
    vecs.push_back(mk(INS, 8'h01, 0, 0, 8'h01, 3'b101, 3, 4));
    vecs.push_back(mk(LKP, 8'h05, 1, 0, 8'h05, 3'b101, 3, 2));
    vecs.push_back(mk(LKP, 8'h01, 1, 0, 8'h01, 3'b001, 3, 2));
    vecs.push_back(mk(LKP, 8'h11, 1, 0, 8'h11, 3'b100, 3, 2));
    vecs.push_back(mk(CLR, 8'hAA, 0, 0, 8'hAA, 3'b000, 0, 2));
    vecs.push_back(mk(LKP, 8'h05, 0, 0, 8'h05, 3'b000, 0, 2));
    vecs.push_back(mk(INS, 8'h05, 0, 0, 8'h05, 3'b001, 1, 2));
    vecs.push_back(mk(INS, 8'h15, 0, 0, 8'h15, 3'b101, 2, 2));
    vecs.push_back(mk(INS, 8'h25, 0, 1, 8'h05, 3'b000, 2, 2 + MAXK));
    vecs.push_back(mk(LKP, 8'h15, 1, 0, 8'h15, 3'b001, 2, 2));
    vecs.push_back(mk(LKP, 8'h25, 1, 0, 8'h25, 3'b101, 2, 2));
    vecs.push_back(mk(LKP, 8'h05, 0, 0, 8'h05, 3'b000, 2, 2));
    vecs.push_back(mk(DEL, 8'h15, 1, 0, 8'h15, 3'b001, 1, 2));
    vecs.push_back(mk(DEL, 8'h15, 0, 0, 8'h15, 3'b000, 1, 2));
    vecs.push_back(mk(LKP, 8'h15, 0, 0, 8'h15, 3'b000, 1, 2));
    vecs.push_back(mk(INS, 8'hFF, 0, 0, 8'hFF, 3'b011, 2, 2));
    vecs.push_back(mk(INS, 8'h3F, 0, 0, 8'h3F, 3'b111, 3, 2));
    vecs.push_back(mk(DEL, 8'h3F, 1, 0, 8'h3F, 3'b111, 2, 2));
    vecs.push_back(mk(LKP, 8'hFF, 1, 0, 8'hFF, 3'b011, 2, 2));
    // The second vector is a duplicate insert: hit stays 1 only there.
    vecs[0].hit = 1'b0;

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready",  {31'd0, req_ready},  32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_hit",   {31'd0, resp_hit},   32'd0);
    chk("reset resp_fail",  {31'd0, resp_fail},  32'd0);
    chk("reset resp_key",   {24'd0, resp_key},   32'd0);
    chk("reset resp_loc",   {29'd0, resp_loc},   32'd0);
    chk("reset count",      {28'd0, count},      32'd0);

    foreach (vecs[i]) do_req(vecs[i]);
    drain();

    // Reset while the engine is mid-eviction.
    do_req(mk(CLR, 8'h00, 0, 0, 8'h00, 3'b000, 0, 2));
    do_req(mk(INS, 8'h05, 0, 0, 8'h05, 3'b001, 1, 2));
    do_req(mk(INS, 8'h15, 0, 0, 8'h15, 3'b101, 2, 2));
    drain();
    req_op = INS; req_key = 8'h25; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("busy in kick req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post abort count",     {28'd0, count},      32'd0);
    chk("post abort req_ready", {31'd0, req_ready},  32'd1);
    chk("post abort resp_valid", {31'd0, resp_valid}, 32'd0);
    do_req(mk(LKP, 8'h05, 0, 0, 8'h05, 3'b000, 0, 2));
    do_req(mk(LKP, 8'h15, 0, 0, 8'h15, 3'b000, 0, 2));
    do_req(mk(LKP, 8'h25, 0, 0, 8'h25, 3'b000, 0, 2));
    drain();

    // Held request: accepted only every third cycle while the engine cycles.
    do_req(mk(INS, 8'h05, 0, 0, 8'h05, 3'b001, 1, 2));
    drain();
    req_op = LKP; req_key = 8'h05; req_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("held req_ready k=%0d", k), {31'd0, req_ready}, {31'd0, (k % 3 == 0)});
      if (req_ready) begin
        sb_t e;
        e.v = mk(LKP, 8'h05, 1, 0, 8'h05, 3'b001, 1, 2);
        e.t0 = cyc;
        sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
